// File: rtl/qpsk_symbol_scheduler.sv
// QPSK symbol scheduler: collects serial bits into symbols and paces samples per symbol.
// Optional SCHED_GRAY_EN loads the symbol register with the Gray-coded shadow value.
module qpsk_symbol_scheduler #(
  parameter int BITS_PER_SYM    = 2,
  parameter int SAMPLES_PER_SYM = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [2:0] sym_sel,
  output logic [7:0] sample_idx,
  output logic       sample_valid,
  output logic       sym_start,
  output logic       underrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;

  localparam logic [1:0] FULL = 2'(BITS_PER_SYM);
  localparam logic [7:0] LAST = 8'(SAMPLES_PER_SYM - 1);

  state_t                  state;
  logic [BITS_PER_SYM-1:0] shadow, sym, sh_next, ld_src;
  logic [1:0]              fill, fill_inc;
  logic                    xfer, full_next, full_now;

  function automatic logic [BITS_PER_SYM-1:0] code(input logic [BITS_PER_SYM-1:0] x);
`ifdef SCHED_GRAY_EN
    return x ^ (x >> 1);
`else
    return x;
`endif
  endfunction

  assign bit_ready = (state == FILL) || ((state == PLAY) && (fill < FULL));
  assign busy      = (state != IDLE);
  assign sym_sel   = 3'(sym);

  assign xfer      = bit_valid & bit_ready;
  assign sh_next   = BITS_PER_SYM'({shadow, bit_in});  // MSB-first shift
  assign fill_inc  = fill + 2'd1;
  assign full_next = xfer && (fill_inc == FULL);
  assign full_now  = (fill == FULL);
  // A bit that completes the shadow on the boundary cycle still counts as ready.
  assign ld_src    = full_now ? shadow : sh_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shadow       <= '0;
      fill         <= '0;
      sym          <= '0;
      sample_idx   <= '0;
      sample_valid <= 1'b0;
      sym_start    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sym_start <= 1'b0;
      case (state)
        IDLE: begin
          sample_idx   <= '0;
          sample_valid <= 1'b0;
          if (enable) begin
            state    <= FILL;
            underrun <= 1'b0;
          end
        end
        FILL: begin
          if (!enable) begin
            state  <= IDLE;
            shadow <= '0;
            fill   <= '0;
          end else if (full_next) begin
            sym          <= code(sh_next);
            shadow       <= '0;
            fill         <= '0;
            state        <= PLAY;
            sample_idx   <= '0;
            sample_valid <= 1'b1;
            sym_start    <= 1'b1;
          end else if (xfer) begin
            shadow <= sh_next;
            fill   <= fill_inc;
          end
        end
        PLAY: begin
          if (sample_idx != LAST) begin
            sample_idx <= sample_idx + 8'd1;
            if (xfer) begin
              shadow <= sh_next;
              fill   <= fill_inc;
            end
          end else if (!enable) begin
            state        <= IDLE;
            shadow       <= '0;
            fill         <= '0;
            sample_idx   <= '0;
            sample_valid <= 1'b0;
          end else if (full_now || full_next) begin
            sym        <= code(ld_src);
            shadow     <= '0;
            fill       <= '0;
            sample_idx <= '0;
            sym_start  <= 1'b1;
          end else begin
            // Underrun: keep any partial bits and wait in FILL.
            underrun     <= 1'b1;
            state        <= FILL;
            sample_idx   <= '0;
            sample_valid <= 1'b0;
            if (xfer) begin
              shadow <= sh_next;
              fill   <= fill_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Bench for qpsk_symbol_scheduler: queue-based model checked every cycle plus directed literal checks.
module tb_qpsk_symbol_scheduler;
  localparam int MB = 2;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst;
  logic en_a, bit_a, bv_a, rdy_a, sv_a, ss_a, ur_a, bz_a;
  logic [2:0] sel_a;
  logic [7:0] idx_a;
  logic en_b, bit_b, bv_b, rdy_b, sv_b, ss_b, ur_b, bz_b;
  logic [2:0] sel_b;
  logic [7:0] idx_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qpsk_symbol_scheduler #(.BITS_PER_SYM(MB), .SAMPLES_PER_SYM(MS)) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .bit_in(bit_a), .bit_valid(bv_a),
    .bit_ready(rdy_a), .sym_sel(sel_a), .sample_idx(idx_a), .sample_valid(sv_a),
    .sym_start(ss_a), .underrun(ur_a), .busy(bz_a));

  qpsk_symbol_scheduler #(.BITS_PER_SYM(3), .SAMPLES_PER_SYM(64)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .bit_in(bit_b), .bit_valid(bv_b),
    .bit_ready(rdy_b), .sym_sel(sel_b), .sample_idx(idx_b), .sample_valid(sv_b),
    .sym_start(ss_b), .underrun(ur_b), .busy(bz_b));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of instance A: 0=idle 1=fill 2=play, shadow kept as a queue of bits.
  int m_st, m_sym, m_idx, m_start, m_und;
  int q[$];

  function automatic int pack(input int b[$]);
    int c = 0;
    foreach (b[i]) c = (c << 1) | b[i];
`ifdef SCHED_GRAY_EN
    c = c ^ (c >> 1);
`endif
    return c;
  endfunction

  function automatic int m_ready();
    return ((m_st == 1) || (m_st == 2 && q.size() < MB)) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = 0; q.delete(); m_sym = 0; m_idx = 0; m_start = 0; m_und = 0;
    end else begin
      automatic int x = (bv_a && m_ready()) ? 1 : 0;
      m_start = 0;
      case (m_st)
        0: if (en_a) begin m_st = 1; m_und = 0; end
        1: begin
          if (!en_a) begin m_st = 0; q.delete(); end
          else if (x) begin
            q.push_back(int'(bit_a));
            if (q.size() == MB) begin
              m_sym = pack(q); q.delete(); m_st = 2; m_idx = 0; m_start = 1;
            end
          end
        end
        default: begin
          if (x) q.push_back(int'(bit_a));
          if (m_idx != MS - 1) m_idx++;
          else if (!en_a) begin m_st = 0; q.delete(); m_idx = 0; end
          else if (q.size() == MB) begin
            m_sym = pack(q); q.delete(); m_idx = 0; m_start = 1;
          end else begin
            m_und = 1; m_st = 1; m_idx = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_ready", int'(rdy_a), m_ready());
      chk("m_sym_sel", int'(sel_a), m_sym);
      chk("m_idx", int'(idx_a), (m_st == 2) ? m_idx : 0);
      chk("m_valid", int'(sv_a), (m_st == 2) ? 1 : 0);
      chk("m_start", int'(ss_a), m_start);
      chk("m_underrun", int'(ur_a), m_und);
      chk("m_busy", int'(bz_a), (m_st != 0) ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic all_zero_a(input string tag);
    chk({tag, "_rdy_a"}, int'(rdy_a), 0);
    chk({tag, "_sel_a"}, int'(sel_a), 0);
    chk({tag, "_idx_a"}, int'(idx_a), 0);
    chk({tag, "_sv_a"}, int'(sv_a), 0);
    chk({tag, "_ss_a"}, int'(ss_a), 0);
    chk({tag, "_ur_a"}, int'(ur_a), 0);
    chk({tag, "_bz_a"}, int'(bz_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    en_a = 0; bit_a = 0; bv_a = 0;
    en_b = 0; bit_b = 0; bv_b = 0;
    #1 rst = 1'b0;
    #1 all_zero_a("reset");
    chk("reset_bz_b", int'(bz_b), 0);
    #10 rst = 1'b1;
    cyc();
    chk("idle_hold_busy", int'(bz_a), 0);

    // Two symbols, last bit of the second arriving on the final sample cycle.
    en_a = 1; cyc();
    chk("fill_busy", int'(bz_a), 1);
    chk("fill_ready", int'(rdy_a), 1);
    bv_a = 1; bit_a = 1; cyc();
    bit_a = 0; cyc();
    chk("s1_sel", int'(sel_a), 2);
    chk("s1_idx", int'(idx_a), 0);
    chk("s1_start", int'(ss_a), 1);
    bit_a = 1; cyc();
    bv_a = 0; cyc(); cyc();
    chk("s1_idx3", int'(idx_a), 3);
    chk("s1_sel3", int'(sel_a), 2);
    bv_a = 1; bit_a = 1; cyc();
    bv_a = 0;
    chk("s2_sel", int'(sel_a), 3);
    chk("s2_start", int'(ss_a), 1);
    chk("s2_valid", int'(sv_a), 1);
    chk("s2_no_underrun", int'(ur_a), 0);
    cyc(); cyc(); cyc();
    chk("s2_idx3", int'(idx_a), 3);

    // Underrun: nothing buffered at the boundary.
    cyc();
    chk("ur_set", int'(ur_a), 1);
    chk("ur_valid", int'(sv_a), 0);
    chk("ur_idx", int'(idx_a), 0);
    cyc(); cyc();
    chk("ur_sticky", int'(ur_a), 1);
    bv_a = 1; bit_a = 0; cyc();
    bit_a = 1; cyc();
    bv_a = 0;
    chk("s3_sel", int'(sel_a), 1);
    chk("s3_start", int'(ss_a), 1);
    chk("s3_ur_sticky", int'(ur_a), 1);
    cyc();
    en_a = 0; cyc();
    chk("stop_idx2", int'(idx_a), 2);
    cyc();
    chk("stop_idx3", int'(idx_a), 3);
    chk("stop_valid3", int'(sv_a), 1);
    cyc();
    chk("stop_busy", int'(bz_a), 0);
    chk("stop_ready", int'(rdy_a), 0);
    chk("stop_ur_kept", int'(ur_a), 1);
    cyc();
    en_a = 1; cyc();
    chk("refill_ur_clear", int'(ur_a), 0);

    // Drop enable mid-symbol on a clean run.
    bv_a = 1; bit_a = 1; cyc(); cyc();
    bv_a = 0;
    chk("s4_sel", int'(sel_a), 3);
    cyc();
    en_a = 0; cyc(); cyc();
    chk("drop_idx3", int'(idx_a), 3);
    cyc();
    chk("drop_busy", int'(bz_a), 0);
    chk("drop_ready", int'(rdy_a), 0);
    chk("drop_no_ur", int'(ur_a), 0);
    chk("drop_sel_hold", int'(sel_a), 3);

    // Instance B: 3-bit symbol, then reset in the middle of playback.
    en_b = 1; cyc();
    bv_b = 1; bit_b = 1; cyc();
    cyc();
    bit_b = 0; cyc();
    bv_b = 0;
`ifdef SCHED_GRAY_EN
    chk("b_sel_gray", int'(sel_b), 5);
`else
    chk("b_sel_bin", int'(sel_b), 6);
`endif
    chk("b_start", int'(ss_b), 1);
    repeat (37) cyc();
    chk("b_idx37", int'(idx_b), 37);
    chk("b_valid37", int'(sv_b), 1);
    #2 rst = 1'b0;
    #1;
    chk("b_rst_sel", int'(sel_b), 0);
    chk("b_rst_idx", int'(idx_b), 0);
    chk("b_rst_valid", int'(sv_b), 0);
    chk("b_rst_ready", int'(rdy_b), 0);
    chk("b_rst_busy", int'(bz_b), 0);
    chk("b_rst_start", int'(ss_b), 0);
    chk("b_rst_ur", int'(ur_b), 0);
    all_zero_a("midrst");
    en_b = 0;
    #3 rst = 1'b1;
    repeat (3) cyc();
    chk("b_post_busy", int'(bz_b), 0);
    chk("b_post_valid", int'(sv_b), 0);
    chk("b_post_ready", int'(rdy_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
